// File: rtl/max_unpool6x6.sv
// 6x6 max-unpool: scatters a latched 3x3 pooled array back into its 2x2 windows,
// one window per clock, using the latched argmax indices; non-argmax cells are zeroed.
module max_unpool6x6 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [2:0][2:0][DATA_WIDTH-1:0]       input_pooled,
    input  logic [2:0][2:0][1:0]                  input_index,
    output logic [5:0][5:0][DATA_WIDTH-1:0]       output_array,
    output logic                                  busy,
    output logic                                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [3:0]                        cnt_q, cnt_d;
    logic [2:0][2:0][DATA_WIDTH-1:0]   val_q, val_d;
    logic [2:0][2:0][1:0]              idx_q, idx_d;
    logic [5:0][5:0][DATA_WIDTH-1:0]   out_q, out_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        idx_d   = idx_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    val_d   = input_pooled;
                    idx_d   = input_index;
                    out_d   = '0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (cnt_q > 4'd8) begin
                    // Unreachable counter values fall back to a clean idle.
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                end else begin
                    for (int rr = 0; rr < 3; rr++) begin
                        for (int cc = 0; cc < 3; cc++) begin
                            if (cnt_q == 4'(rr * 3 + cc)) begin
                                for (int dr = 0; dr < 2; dr++) begin
                                    for (int dc = 0; dc < 2; dc++) begin
                                        out_d[3'(2 * rr + dr)][3'(2 * cc + dc)] =
                                            (idx_q[2'(rr)][2'(cc)] == 2'(dr * 2 + dc)) ?
                                            val_q[2'(rr)][2'(cc)] : '0;
                                    end
                                end
                            end
                        end
                    end
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd8) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            S_DONE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            val_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign output_array = out_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
